mem_bus_unit: RTL and testbench
===============================

Name: mem_bus_unit

Overview:
- Parametrised successor to the MEM-stage load/store logic.
- Performs LB/LBU/LH/LHU/LW/SB/SH/SW/LL/SC over a request/acknowledge data bus. Slaves may take any number of cycles.
- Stalls the pipeline while a transaction is outstanding. Detects misaligned addresses and bus errors/timeouts.
- Owns the LLbit and the LL link address internally. Sits between EX/MEM and MEM/WB; the wrapper muxes rsp_data_o into the writeback data.

Parameters:
ADDR_W, 32, width of the address path.
TIMEOUT, 16, max cycles spent in BUS before a forced bus error; 0 disables the timeout.
LL_CHECK_ADDR, 1, 1 = SC succeeds only if its word address equals the LL link address; 0 = LLbit alone decides.

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
req_valid_i  in  1  memory op presented by EX/MEM
req_op_i  in  4  op code (defines.v MEMOP_*)
req_addr_i  in  ADDR_W  effective address
req_wdata_i  in  32  store data (rt)
flush_i  in  1  exception/eret flush
stall_o  out  1  stall request to the pipeline controller
rsp_valid_o  out  1  result valid, one cycle
rsp_data_o  out  32  load result, or SC flag (1/0)
exc_adel_o  out  1  misaligned load/LL
exc_ades_o  out  1  misaligned store/SC
exc_buserr_o  out  1  bus_err_i seen or timeout
llbit_o  out  1  current LLbit
bus_req_o  out  1  transaction request
bus_we_o  out  1  1 = write
bus_addr_o  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
bus_sel_o  out  4  byte lanes, big-endian ([3] = byte 0 = bits 31:24)
bus_wdata_o  out  32  write data, replicated across lanes
bus_ack_i  in  1  transaction done
bus_rdata_i  in  32  read data, valid with ack
bus_err_i  in  1  transaction failed, valid instead of ack

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE.
  - All outputs 0.
  - LLbit=0, link address=0, timeout counter=0.
- States:
  - IDLE: no bus activity.
  - BUS: bus_req_o held at 1.
  - RESP: rsp_valid_o=1 for exactly one cycle, then IDLE.
- Op decoding:
  - MEMOP_NOP and unused codes: ignored, no stall.
  - Alignment rule: LH/LHU/SH need addr[0]=0. LW/LL/SW/SC need addr[1:0]=0.
- IDLE, req_valid_i=1 with a legal op (and flush_i=0):
  - Misaligned: go to RESP with exc_adel_o or exc_ades_o set. No bus access. LLbit unchanged.
  - SC whose check fails (LLbit=0, or address mismatch when LL_CHECK_ADDR=1): go to RESP with rsp_data_o=0. No bus access. LLbit cleared.
  - Otherwise: register bus_* and go to BUS.
    - bus_sel_o: byte → one-hot per addr[1:0] (00→1000, 11→0001); half → 1100 or 0011; word → 1111.
- stall_o (combinational):
  - 1 while in BUS.
  - 1 in IDLE while a legal req_valid_i is presented and flush_i=0.
  - 0 in RESP.
  - Upstream holds the request stable while stall_o=1. The pipeline advances at the end of the RESP cycle. req_valid_i is ignored in RESP.
- BUS:
  - Bus outputs stay stable. The timeout counter increments each cycle.
  - bus_ack_i → RESP, bus_req_o=0 on the next edge. Load data is captured, lane-selected, then sign- or zero-extended.
  - bus_err_i, or counter reaching TIMEOUT (TIMEOUT>0) → RESP with exc_buserr_o=1 and rsp_data_o=0.
  - ack and err in the same cycle: err wins.
- Latency:
  - Misaligned access or failed SC: rsp_valid_o in cycle 1 after acceptance.
  - Ack in the first BUS cycle: rsp_valid_o in cycle 2. Each wait cycle adds 1.
- LLbit:
  - Set, and link address = addr word, when LL completes with ack.
  - Cleared by: any SC completion (success or fail); flush_i in any state; SB/SH/SW completing with ack to the linked word.
  - LL or SC ending in a bus error leaves LLbit=0.
  - flush_i and an LL completion in the same cycle: flush wins.
- flush_i:
  - In IDLE: beats acceptance; nothing is accepted.
  - In BUS: the transaction runs to ack/err (no bus abort). A sticky flag is set; on completion go directly to IDLE with no rsp_valid_o and no exception.
  - In RESP: rsp_valid_o is suppressed.
- SC success: rsp_data_o=32'h1, with a word write to the bus.

Decomposition:
- defines.v:
  - MEMOP_* codes: NOP 0, LB 1, LBU 2, LH 3, LHU 4, LW 5, SB 6, SH 7, SW 8, LL 9, SC 10.
  - MemOpBus width (4).
  - State encodings: IDLE, BUS, RESP.
- Sub-module mem_lane_align (combinational):
  - Op + addr[1:0] → bus_sel, replicated store data, misaligned flag.
  - Op + addr[1:0] + rdata → extended load result.
  - Top keeps the FSM, timeout counter, LLbit and flush logic.

Test Plan:
- LB addr 0x103, rdata 0x11223380, ack after 2 wait cycles → sel 0001; stall_o=1 for 4 cycles (acceptance + 3 BUS); rsp_data_o=0xFFFFFF80; LBU of the same access → 0x00000080.
- SH addr 0x202, wdata 0x0000BEEF, ack immediately → bus_we_o=1, sel 0011, bus_wdata_o=0xBEEFBEEF, bus_addr_o=0x200; rsp in cycle 2.
- LW addr 0x101 → exc_adel_o=1 in cycle 1; bus_req_o never asserted. SW addr 0x102 → exc_ades_o=1.
- LL 0x400 (ack), then SC 0x400 → bus write, rsp_data_o=1, llbit_o=0. Repeat with SW 0x400 between LL and SC → SC returns 0, no bus access.
- LL 0x400 then flush_i pulse → llbit_o=0. Flush during BUS of LW → transaction completes on ack; no rsp_valid_o.
- Slave never acks, TIMEOUT=16 → exc_buserr_o=1 after 16 BUS cycles; bus_req_o drops; rsp_data_o=0.

Source files
------------

// File: rtl/mem_bus_unit_pkg.sv
// rtl/mem_bus_unit_pkg.sv - memory op codes, FSM states and op classification helpers
package mem_bus_unit_pkg;

  localparam int MEMOP_W = 4;

  localparam logic [MEMOP_W-1:0] MEMOP_NOP = 4'd0;
  localparam logic [MEMOP_W-1:0] MEMOP_LB  = 4'd1;
  localparam logic [MEMOP_W-1:0] MEMOP_LBU = 4'd2;
  localparam logic [MEMOP_W-1:0] MEMOP_LH  = 4'd3;
  localparam logic [MEMOP_W-1:0] MEMOP_LHU = 4'd4;
  localparam logic [MEMOP_W-1:0] MEMOP_LW  = 4'd5;
  localparam logic [MEMOP_W-1:0] MEMOP_SB  = 4'd6;
  localparam logic [MEMOP_W-1:0] MEMOP_SH  = 4'd7;
  localparam logic [MEMOP_W-1:0] MEMOP_SW  = 4'd8;
  localparam logic [MEMOP_W-1:0] MEMOP_LL  = 4'd9;
  localparam logic [MEMOP_W-1:0] MEMOP_SC  = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic op_legal(input logic [MEMOP_W-1:0] op);
    return (op >= MEMOP_LB) && (op <= MEMOP_SC);
  endfunction

  function automatic logic op_is_load(input logic [MEMOP_W-1:0] op);
    return (op == MEMOP_LB) || (op == MEMOP_LBU) || (op == MEMOP_LH) ||
           (op == MEMOP_LHU) || (op == MEMOP_LW) || (op == MEMOP_LL);
  endfunction

endpackage

// File: rtl/mem_bus_unit_lane_align.sv
// rtl/mem_bus_unit_lane_align.sv - byte-lane select, store replication, alignment check and load extension
module mem_bus_unit_lane_align
  import mem_bus_unit_pkg::*;
(
  input  logic [MEMOP_W-1:0] op,
  input  logic [1:0]         addr_lo,
  input  logic [31:0]        wdata,
  input  logic [31:0]        rdata,
  output logic [3:0]         sel,
  output logic [31:0]        wdata_rep,
  output logic               misaligned,
  output logic [31:0]        load_data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Big-endian lane decode: byte 0 lives in bits 31:24.
  always_comb begin
    sel        = 4'b0000;
    wdata_rep  = wdata;
    misaligned = 1'b0;
    load_data  = 32'h0;
    byte_v     = rdata[31:24];
    half_v     = addr_lo[1] ? rdata[15:0] : rdata[31:16];

    case (addr_lo)
      2'd0:    byte_v = rdata[31:24];
      2'd1:    byte_v = rdata[23:16];
      2'd2:    byte_v = rdata[15:8];
      default: byte_v = rdata[7:0];
    endcase

    case (op)
      MEMOP_LB, MEMOP_LBU, MEMOP_SB: begin
        sel       = 4'b1000 >> addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      MEMOP_LH, MEMOP_LHU, MEMOP_SH: begin
        sel        = addr_lo[1] ? 4'b0011 : 4'b1100;
        wdata_rep  = {2{wdata[15:0]}};
        misaligned = addr_lo[0];
      end
      MEMOP_LW, MEMOP_LL, MEMOP_SW, MEMOP_SC: begin
        sel        = 4'b1111;
        misaligned = |addr_lo;
      end
      default: ;
    endcase

    case (op)
      MEMOP_LB:           load_data = {{24{byte_v[7]}}, byte_v};
      MEMOP_LBU:          load_data = {24'h0, byte_v};
      MEMOP_LH:           load_data = {{16{half_v[15]}}, half_v};
      MEMOP_LHU:          load_data = {16'h0, half_v};
      MEMOP_LW, MEMOP_LL: load_data = rdata;
      default:            load_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_bus_unit.sv
// rtl/mem_bus_unit.sv - MEM-stage load/store unit over a request/acknowledge bus with LL/SC support
module mem_bus_unit
  import mem_bus_unit_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int TIMEOUT       = 16,
  parameter bit LL_CHECK_ADDR = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid_i,
  input  logic [MEMOP_W-1:0] req_op_i,
  input  logic [ADDR_W-1:0]  req_addr_i,
  input  logic [31:0]        req_wdata_i,
  input  logic               flush_i,
  output logic               stall_o,
  output logic               rsp_valid_o,
  output logic [31:0]        rsp_data_o,
  output logic               exc_adel_o,
  output logic               exc_ades_o,
  output logic               exc_buserr_o,
  output logic               llbit_o,
  output logic               bus_req_o,
  output logic               bus_we_o,
  output logic [ADDR_W-1:0]  bus_addr_o,
  output logic [3:0]         bus_sel_o,
  output logic [31:0]        bus_wdata_o,
  input  logic               bus_ack_i,
  input  logic [31:0]        bus_rdata_i,
  input  logic               bus_err_i
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) + 1 : 1;

  state_t               state_q, state_d;
  logic [MEMOP_W-1:0]   op_q;
  logic [1:0]           addr_lo_q;
  logic                 flushed_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 llbit_q;
  logic [ADDR_W-3:0]    link_q;
  logic [31:0]          rsp_data_q;
  logic                 adel_q, ades_q, buserr_q;
  logic                 bus_req_q, bus_we_q;
  logic [ADDR_W-1:0]    bus_addr_q;
  logic [3:0]           bus_sel_q;
  logic [31:0]          bus_wdata_q;

  logic [MEMOP_W-1:0]   op_mux;
  logic [1:0]           addr_lo_mux;
  logic [3:0]           sel;
  logic [31:0]          wdata_rep;
  logic                 misaligned;
  logic [31:0]          load_data;

  logic accept, is_sc_req, sc_ok, sc_fail, timeout_hit, bus_fail, bus_done;

  // The aligner sees the incoming request in IDLE and the latched op while the bus runs.
  assign op_mux      = (state_q == ST_IDLE) ? req_op_i : op_q;
  assign addr_lo_mux = (state_q == ST_IDLE) ? req_addr_i[1:0] : addr_lo_q;

  mem_bus_unit_lane_align u_align (
    .op         (op_mux),
    .addr_lo    (addr_lo_mux),
    .wdata      (req_wdata_i),
    .rdata      (bus_rdata_i),
    .sel        (sel),
    .wdata_rep  (wdata_rep),
    .misaligned (misaligned),
    .load_data  (load_data)
  );

  assign accept      = (state_q == ST_IDLE) && req_valid_i && op_legal(req_op_i) && !flush_i;
  assign is_sc_req   = (req_op_i == MEMOP_SC);
  assign sc_ok       = llbit_q && (!LL_CHECK_ADDR || (link_q == req_addr_i[ADDR_W-1:2]));
  assign sc_fail     = accept && is_sc_req && !misaligned && !sc_ok;
  assign timeout_hit = (TIMEOUT > 0) && (32'(cnt_q) == 32'(TIMEOUT - 1));
  assign bus_fail    = bus_err_i || timeout_hit;
  assign bus_done    = (state_q == ST_BUS) && (bus_ack_i || bus_fail);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state: short-circuit to RESP for misaligned/failed SC; flushed bus ops return silently.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = (misaligned || sc_fail) ? ST_RESP : ST_BUS;
      ST_BUS:  if (bus_done) state_d = (flushed_q || flush_i) ? ST_IDLE : ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Request capture, bus drive, timeout counter and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q        <= MEMOP_NOP;
      addr_lo_q   <= 2'b00;
      flushed_q   <= 1'b0;
      cnt_q       <= '0;
      rsp_data_q  <= 32'h0;
      adel_q      <= 1'b0;
      ades_q      <= 1'b0;
      buserr_q    <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_sel_q   <= 4'b0000;
      bus_wdata_q <= 32'h0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_q       <= req_op_i;
            addr_lo_q  <= req_addr_i[1:0];
            cnt_q      <= '0;
            flushed_q  <= 1'b0;
            rsp_data_q <= 32'h0;
            adel_q     <= misaligned && op_is_load(req_op_i);
            ades_q     <= misaligned && !op_is_load(req_op_i);
            buserr_q   <= 1'b0;
            if (!misaligned && !sc_fail) begin
              bus_req_q   <= 1'b1;
              bus_we_q    <= !op_is_load(req_op_i);
              bus_addr_q  <= {req_addr_i[ADDR_W-1:2], 2'b00};
              bus_sel_q   <= sel;
              bus_wdata_q <= wdata_rep;
            end
          end
        end
        ST_BUS: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (flush_i) flushed_q <= 1'b1;
          if (bus_done) begin
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_sel_q   <= 4'b0000;
            bus_wdata_q <= 32'h0;
            flushed_q   <= 1'b0;
            if (bus_fail) begin
              buserr_q   <= 1'b1;
              rsp_data_q <= 32'h0;
            end else if (op_is_load(op_q)) begin
              rsp_data_q <= load_data;
            end else if (op_q == MEMOP_SC) begin
              rsp_data_q <= 32'h1;
            end else begin
              rsp_data_q <= 32'h0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // LL link tracking; a flush in any state overrides every other update.
  always_ff @(posedge clk) begin
    if (rst) begin
      llbit_q <= 1'b0;
      link_q  <= '0;
    end else if (flush_i) begin
      llbit_q <= 1'b0;
    end else if (sc_fail) begin
      llbit_q <= 1'b0;
    end else if (bus_done) begin
      if (bus_fail) begin
        if ((op_q == MEMOP_LL) || (op_q == MEMOP_SC)) llbit_q <= 1'b0;
      end else begin
        case (op_q)
          MEMOP_LL: begin
            if (!flushed_q) begin
              llbit_q <= 1'b1;
              link_q  <= bus_addr_q[ADDR_W-1:2];
            end
          end
          MEMOP_SC: llbit_q <= 1'b0;
          MEMOP_SB, MEMOP_SH, MEMOP_SW:
            if (bus_addr_q[ADDR_W-1:2] == link_q) llbit_q <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  assign stall_o      = (state_q == ST_BUS) || accept;
  assign rsp_valid_o  = (state_q == ST_RESP) && !flush_i;
  assign rsp_data_o   = rsp_valid_o ? rsp_data_q : 32'h0;
  assign exc_adel_o   = rsp_valid_o && adel_q;
  assign exc_ades_o   = rsp_valid_o && ades_q;
  assign exc_buserr_o = rsp_valid_o && buserr_q;
  assign llbit_o      = llbit_q;
  assign bus_req_o    = bus_req_q;
  assign bus_we_o     = bus_we_q;
  assign bus_addr_o   = bus_addr_q;
  assign bus_sel_o    = bus_sel_q;
  assign bus_wdata_o  = bus_wdata_q;

endmodule

// File: tb/tb_mem_bus_unit.sv
// tb/tb_mem_bus_unit.sv - directed vector bench for mem_bus_unit
module tb_mem_bus_unit;

  localparam logic [3:0] OP_NOP = 4'd0, OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3, OP_LHU = 4'd4,
                         OP_LW = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7, OP_SW = 4'd8, OP_LL = 4'd9,
                         OP_SC = 4'd10;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [3:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic        flush;
  logic        stall_o, rsp_valid_o, exc_adel_o, exc_ades_o, exc_buserr_o, llbit_o;
  logic [31:0] rsp_data_o;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_sel_o;
  logic        bus_ack, bus_err;
  logic [31:0] bus_rdata;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mem_bus_unit #(.ADDR_W(32), .TIMEOUT(16), .LL_CHECK_ADDR(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_op_i(req_op), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .flush_i(flush), .stall_o(stall_o), .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o),
    .exc_adel_o(exc_adel_o), .exc_ades_o(exc_ades_o), .exc_buserr_o(exc_buserr_o),
    .llbit_o(llbit_o), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o), .bus_ack_i(bus_ack),
    .bus_rdata_i(bus_rdata), .bus_err_i(bus_err)
  );

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] addr, wdata, rdata;
    int          waits;
    int          errm;      // 0 = ack, 1 = err, 2 = ack and err together
    logic        exp_bus, exp_we;
    logic [3:0]  exp_sel;
    logic [31:0] exp_baddr, exp_bwdata;
    int          exp_bcyc;
    logic [31:0] exp_data;
    logic        exp_adel, exp_ades, exp_berr, exp_ll;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic add(input string nm, input logic [3:0] op, input logic [31:0] addr, wdata, rdata,
                     input int waits, errm, input logic eb, ewe, input logic [3:0] esel,
                     input logic [31:0] ebaddr, ebwdata, input int ebcyc, input logic [31:0] edata,
                     input logic eadel, eades, eberr, ell);
    vec_t v;
    v.name = nm; v.op = op; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.waits = waits; v.errm = errm; v.exp_bus = eb; v.exp_we = ewe; v.exp_sel = esel;
    v.exp_baddr = ebaddr; v.exp_bwdata = ebwdata; v.exp_bcyc = ebcyc; v.exp_data = edata;
    v.exp_adel = eadel; v.exp_ades = eades; v.exp_berr = eberr; v.exp_ll = ell;
    vq.push_back(v);
  endtask

  task automatic run_vec(input vec_t v);
    int bcyc = 0, stalls = 0, lat = -1, exp_lat;
    logic got = 1'b0, seen = 1'b0, stable = 1'b1;
    logic [31:0] data = 0, ba = 0, bw = 0;
    logic [3:0] sel = 0;
    logic we = 0, adel = 0, ades = 0, berr = 0;
    exp_lat = v.exp_bus ? v.exp_bcyc + 1 : 1;
    @(negedge clk);
    req_valid = 1'b1; req_op = v.op; req_addr = v.addr; req_wdata = v.wdata;
    for (int c = 0; c < 40 && !got; c++) begin
      #1;
      if (bus_req_o) begin
        if (!seen) begin
          seen = 1'b1; sel = bus_sel_o; we = bus_we_o; ba = bus_addr_o; bw = bus_wdata_o;
        end else if (bus_sel_o !== sel || bus_we_o !== we || bus_addr_o !== ba || bus_wdata_o !== bw) begin
          stable = 1'b0;
        end
        bus_ack   = (v.errm != 1) && (bcyc == v.waits);
        bus_err   = (v.errm != 0) && (bcyc == v.waits);
        bus_rdata = bus_ack ? v.rdata : 32'hDEADBEEF;
        bcyc++;
      end else begin
        bus_ack = 1'b0; bus_err = 1'b0;
      end
      if (stall_o) stalls++;
      if (rsp_valid_o) begin
        got = 1'b1; lat = c; data = rsp_data_o;
        adel = exc_adel_o; ades = exc_ades_o; berr = exc_buserr_o;
      end
      @(negedge clk);
    end
    req_valid = 1'b0; bus_ack = 1'b0; bus_err = 1'b0;
    #1;
    chk({v.name, " rsp_valid"}, 32'(got), 32'd1);
    chk({v.name, " latency"}, lat, exp_lat);
    chk({v.name, " stall_cycles"}, stalls, exp_lat);
    chk({v.name, " rsp_data"}, data, v.exp_data);
    chk({v.name, " exc_adel"}, 32'(adel), 32'(v.exp_adel));
    chk({v.name, " exc_ades"}, 32'(ades), 32'(v.exp_ades));
    chk({v.name, " exc_buserr"}, 32'(berr), 32'(v.exp_berr));
    chk({v.name, " bus_used"}, 32'(seen), 32'(v.exp_bus));
    chk({v.name, " bus_cycles"}, bcyc, v.exp_bcyc);
    chk({v.name, " llbit"}, 32'(llbit_o), 32'(v.exp_ll));
    chk({v.name, " bus_idle_after"}, 32'(bus_req_o), 32'd0);
    if (v.exp_bus) begin
      chk({v.name, " bus_sel"}, 32'(sel), 32'(v.exp_sel));
      chk({v.name, " bus_we"}, 32'(we), 32'(v.exp_we));
      chk({v.name, " bus_addr"}, ba, v.exp_baddr);
      chk({v.name, " bus_stable"}, 32'(stable), 32'd1);
      if (v.exp_we) chk({v.name, " bus_wdata"}, bw, v.exp_bwdata);
    end
  endtask

  initial begin
    int rv_seen;
    rst = 1'b1; req_valid = 1'b0; req_op = OP_NOP; req_addr = 0; req_wdata = 0;
    flush = 1'b0; bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = 0;

    //        name          op      addr          wdata         rdata         wt ee bus we sel      baddr         bwdata        bc data          adl ads ber ll
    add("lb_103",     OP_LB,  32'h103, 32'h0,        32'h11223380, 2, 0, 1, 0, 4'b0001, 32'h100, 32'h0,        3, 32'hFFFFFF80, 0, 0, 0, 0);
    add("lbu_103",    OP_LBU, 32'h103, 32'h0,        32'h11223380, 2, 0, 1, 0, 4'b0001, 32'h100, 32'h0,        3, 32'h00000080, 0, 0, 0, 0);
    add("sh_202",     OP_SH,  32'h202, 32'h0000BEEF, 32'h0,        0, 0, 1, 1, 4'b0011, 32'h200, 32'hBEEFBEEF, 1, 32'h0,        0, 0, 0, 0);
    add("lw_101",     OP_LW,  32'h101, 32'h0,        32'h0,        0, 0, 0, 0, 4'b0000, 32'h0,   32'h0,        0, 32'h0,        1, 0, 0, 0);
    add("sw_102",     OP_SW,  32'h102, 32'h1234,     32'h0,        0, 0, 0, 0, 4'b0000, 32'h0,   32'h0,        0, 32'h0,        0, 1, 0, 0);
    add("lh_102",     OP_LH,  32'h102, 32'h0,        32'h12348765, 1, 0, 1, 0, 4'b0011, 32'h100, 32'h0,        2, 32'hFFFF8765, 0, 0, 0, 0);
    add("lhu_100",    OP_LHU, 32'h100, 32'h0,        32'h9ABC0000, 0, 0, 1, 0, 4'b1100, 32'h100, 32'h0,        1, 32'h00009ABC, 0, 0, 0, 0);
    add("lh_101",     OP_LH,  32'h101, 32'h0,        32'h0,        0, 0, 0, 0, 4'b0000, 32'h0,   32'h0,        0, 32'h0,        1, 0, 0, 0);
    add("sb_101",     OP_SB,  32'h101, 32'h000000A5, 32'h0,        0, 0, 1, 1, 4'b0100, 32'h100, 32'hA5A5A5A5, 1, 32'h0,        0, 0, 0, 0);
    add("ll_400",     OP_LL,  32'h400, 32'h0,        32'hCAFEF00D, 0, 0, 1, 0, 4'b1111, 32'h400, 32'h0,        1, 32'hCAFEF00D, 0, 0, 0, 1);
    add("sc_400_ok",  OP_SC,  32'h400, 32'h00000055, 32'h0,        0, 0, 1, 1, 4'b1111, 32'h400, 32'h00000055, 1, 32'h1,        0, 0, 0, 0);
    add("ll_400_w1",  OP_LL,  32'h400, 32'h0,        32'h1,        1, 0, 1, 0, 4'b1111, 32'h400, 32'h0,        2, 32'h1,        0, 0, 0, 1);
    add("sw_400",     OP_SW,  32'h400, 32'h7,        32'h0,        0, 0, 1, 1, 4'b1111, 32'h400, 32'h7,        1, 32'h0,        0, 0, 0, 0);
    add("sc_400_nol", OP_SC,  32'h400, 32'h9,        32'h0,        0, 0, 0, 0, 4'b0000, 32'h0,   32'h0,        0, 32'h0,        0, 0, 0, 0);
    add("ll_400_c",   OP_LL,  32'h400, 32'h0,        32'h0,        0, 0, 1, 0, 4'b1111, 32'h400, 32'h0,        1, 32'h0,        0, 0, 0, 1);
    add("sc_404_mis", OP_SC,  32'h404, 32'h9,        32'h0,        0, 0, 0, 0, 4'b0000, 32'h0,   32'h0,        0, 32'h0,        0, 0, 0, 0);
    add("ll_400_d",   OP_LL,  32'h400, 32'h0,        32'h5,        0, 0, 1, 0, 4'b1111, 32'h400, 32'h0,        1, 32'h5,        0, 0, 0, 1);
    add("ll_err",     OP_LL,  32'h400, 32'h0,        32'h5,        0, 1, 1, 0, 4'b1111, 32'h400, 32'h0,        1, 32'h0,        0, 0, 1, 0);
    add("ll_400_e",   OP_LL,  32'h400, 32'h0,        32'h6,        0, 0, 1, 0, 4'b1111, 32'h400, 32'h0,        1, 32'h6,        0, 0, 0, 1);
    add("sb_503",     OP_SB,  32'h503, 32'h0000003C, 32'h0,        0, 0, 1, 1, 4'b0001, 32'h500, 32'h3C3C3C3C, 1, 32'h0,        0, 0, 0, 1);
    add("sc_400_ok2", OP_SC,  32'h400, 32'h000000AB, 32'h0,        1, 0, 1, 1, 4'b1111, 32'h400, 32'h000000AB, 2, 32'h1,        0, 0, 0, 0);
    add("lw_ack_err", OP_LW,  32'h500, 32'h0,        32'h77,       1, 2, 1, 0, 4'b1111, 32'h500, 32'h0,        2, 32'h0,        0, 0, 1, 0);
    add("lw_timeout", OP_LW,  32'h504, 32'h0,        32'h0,       99, 0, 1, 0, 4'b1111, 32'h504, 32'h0,       16, 32'h0,        0, 0, 1, 0);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("reset stall", 32'(stall_o), 0);
    chk("reset rsp_valid", 32'(rsp_valid_o), 0);
    chk("reset rsp_data", rsp_data_o, 0);
    chk("reset excs", {29'h0, exc_adel_o, exc_ades_o, exc_buserr_o}, 0);
    chk("reset llbit", 32'(llbit_o), 0);
    chk("reset bus_req_we", {30'h0, bus_req_o, bus_we_o}, 0);
    chk("reset bus_addr", bus_addr_o, 0);
    chk("reset bus_sel_wdata", bus_wdata_o | 32'(bus_sel_o), 0);
    rst = 1'b0;

    // NOP is ignored: no stall, no bus, no response
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_NOP; req_addr = 32'h100; #1;
    chk("nop stall", 32'(stall_o), 0);
    rv_seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      if (rsp_valid_o || bus_req_o) rv_seen++;
    end
    chk("nop no_activity", rv_seen, 0);
    req_valid = 1'b0;

    for (int i = 0; i < vq.size(); i++) run_vec(vq[i]);

    // Flush in IDLE clears LLbit
    run_vec(vq[9]);
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0; #1;
    chk("flush_idle llbit", 32'(llbit_o), 0);

    // Flush in IDLE beats acceptance
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_LW; req_addr = 32'h600; flush = 1'b1; #1;
    chk("flush_accept stall", 32'(stall_o), 0);
    @(negedge clk); flush = 1'b0; req_valid = 1'b0; #1;
    chk("flush_accept no_bus", 32'(bus_req_o), 0);
    chk("flush_accept no_rsp", 32'(rsp_valid_o), 0);

    // Flush during BUS: transaction completes on ack, no response
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_LW; req_addr = 32'h600;
    @(negedge clk); #1;
    chk("flush_bus req_up", 32'(bus_req_o), 1);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0; req_valid = 1'b0; #1;
    chk("flush_bus held", 32'(bus_req_o), 1);
    chk("flush_bus stall", 32'(stall_o), 1);
    bus_ack = 1'b1; bus_rdata = 32'h12345678;
    @(negedge clk); bus_ack = 1'b0;
    rv_seen = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (rsp_valid_o || exc_buserr_o || bus_req_o || stall_o) rv_seen++;
      @(negedge clk);
    end
    chk("flush_bus silent", rv_seen, 0);

    // Flush in RESP suppresses the response
    req_valid = 1'b1; req_op = OP_LW; req_addr = 32'h101;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b1; #1;
    chk("flush_resp rsp_valid", 32'(rsp_valid_o), 0);
    chk("flush_resp adel", 32'(exc_adel_o), 0);
    @(negedge clk); flush = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
